// File: rtl/multiply_pkg.sv
// Shared state type and default operand width for the sequential shift-add multiplier.
package multiply_pkg;

    localparam int MUL_DEFAULT_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } mul_state_t;

endpackage

// File: rtl/multiply_seq.sv
// Sequential shift-add multiplier (WIDTH x WIDTH -> 2*WIDTH), signed or unsigned per operation.
// Optional MULTIPLY_SEQ_ZERO_SKIP_EN: zero operands finish in one cycle instead of WIDTH+2.
module multiply_seq
    import multiply_pkg::*;
#(
    parameter int WIDTH = MUL_DEFAULT_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 overflow,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mul_state_t           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic                 r_neg;
    logic                 r_signed;
    logic [2*WIDTH-1:0]   r_prod;
    logic                 r_ovf;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_fix_prod;
    logic                 w_ovf;
`ifdef MULTIPLY_SEQ_ZERO_SKIP_EN
    logic                 w_zero;
`endif

    // Unsigned negation of the most-negative value yields 2^(WIDTH-1), the wanted magnitude.
    assign w_a_neg = signed_mode & multiplicand[WIDTH-1];
    assign w_b_neg = signed_mode & multiplier[WIDTH-1];
    assign w_a_mag = w_a_neg ? -multiplicand : multiplicand;
    assign w_b_mag = w_b_neg ? -multiplier   : multiplier;

    assign w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    assign w_fix_prod = r_neg ? -r_prod : r_prod;
    assign w_ovf      = r_signed
                      ? !((&w_fix_prod[2*WIDTH-1:WIDTH-1]) || (~|w_fix_prod[2*WIDTH-1:WIDTH-1]))
                      : (|w_fix_prod[2*WIDTH-1:WIDTH]);

`ifdef MULTIPLY_SEQ_ZERO_SKIP_EN
    assign w_zero = (multiplicand == '0) || (multiplier == '0);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_neg    <= 1'b0;
            r_signed <= 1'b0;
            r_prod   <= '0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_ovf    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_signed <= signed_mode;
                        r_mcand  <= w_a_mag;
                        r_neg    <= w_a_neg ^ w_b_neg;
`ifdef MULTIPLY_SEQ_ZERO_SKIP_EN
                        if (w_zero) begin
                            r_prod  <= '0;
                            r_neg   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_prod  <= {{WIDTH{1'b0}}, w_b_mag};
                            r_state <= CALC;
                        end
`else
                        r_prod  <= {{WIDTH{1'b0}}, w_b_mag};
                        r_state <= CALC;
`endif
                    end
                end
                CALC: begin
                    // Multiplier bits are consumed from the low half as the partial sum shifts in on top.
                    if (r_prod[0]) begin
                        r_prod <= {w_sum, r_prod[WIDTH-1:1]};
                    end else begin
                        r_prod <= r_prod >> 1;
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_prod  <= w_fix_prod;
                    r_ovf   <= w_ovf;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign product  = r_prod;
    assign overflow = r_ovf;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_multiply_seq.sv
// Bench for multiply_seq: 12-bit and 8-bit instances, per-cycle arithmetic model plus directed literal cases.
module tb_multiply_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MULTIPLY_SEQ_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic        rstn  [2];
    logic        start [2];
    logic        sm    [2];
    logic        ovf   [2];
    logic        busy  [2];
    logic        done  [2];
    logic [11:0] a12, b12;
    logic [7:0]  a8, b8;
    logic [23:0] prod12;
    logic [15:0] prod8;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int     m_left   [2] = '{0, 0};
    longint m_exp_p  [2] = '{0, 0};
    longint m_hold_p [2] = '{0, 0};
    bit     m_exp_o  [2] = '{0, 0};
    bit     m_hold_o [2] = '{0, 0};

    multiply_seq #(.WIDTH(12)) dut12 (
        .clock(clk), .reset_n(rstn[0]), .start(start[0]), .signed_mode(sm[0]),
        .multiplicand(a12), .multiplier(b12), .product(prod12),
        .overflow(ovf[0]), .busy(busy[0]), .done(done[0])
    );

    multiply_seq #(.WIDTH(8)) dut8 (
        .clock(clk), .reset_n(rstn[1]), .start(start[1]), .signed_mode(sm[1]),
        .multiplicand(a8), .multiplier(b8), .product(prod8),
        .overflow(ovf[1]), .busy(busy[1]), .done(done[1])
    );

    function automatic int wid(int k);
        return (k == 0) ? 12 : 8;
    endfunction

    function automatic longint geta(int k);
        return (k == 0) ? longint'(a12) : longint'(a8);
    endfunction

    function automatic longint getb(int k);
        return (k == 0) ? longint'(b12) : longint'(b8);
    endfunction

    function automatic longint getp(int k);
        return (k == 0) ? longint'(prod12) : longint'(prod8);
    endfunction

    function automatic longint sx(longint v, int w, bit s);
        longint one = 1;
        if (s && v[w-1]) return v - (one << w);
        return v;
    endfunction

    function automatic longint model_p(longint a, longint b, bit s, int w);
        longint one = 1;
        longint p;
        p = sx(a, w, s) * sx(b, w, s);
        return p & ((one << (2 * w)) - 1);
    endfunction

    function automatic bit model_o(longint a, longint b, bit s, int w);
        longint one = 1;
        longint p;
        p = sx(a, w, s) * sx(b, w, s);
        if (s) return (p < -(one << (w - 1))) || (p > (one << (w - 1)) - 1);
        return p >= (one << w);
    endfunction

    task automatic check(string name, longint act, longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: an operation occupies WIDTH+2 cycles (1 for a skipped zero), the last being the done cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (!rstn[k]) begin
                m_left[k]   <= 0;
                m_hold_p[k] <= 0;
                m_hold_o[k] <= 1'b0;
            end else if (m_left[k] > 0) begin
                m_left[k] <= m_left[k] - 1;
                if (m_left[k] == 1) begin
                    m_hold_p[k] <= m_exp_p[k];
                    m_hold_o[k] <= m_exp_o[k];
                end
            end else if (start[k]) begin
                m_exp_p[k] <= model_p(geta(k), getb(k), sm[k], wid(k));
                m_exp_o[k] <= model_o(geta(k), getb(k), sm[k], wid(k));
                m_left[k]  <= (ZS && (geta(k) == 0 || getb(k) == 0)) ? 1 : wid(k) + 2;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                check($sformatf("busy[%0d] c%0d", k, cyc), longint'(busy[k]), longint'(m_left[k] > 0));
                check($sformatf("done[%0d] c%0d", k, cyc), longint'(done[k]), longint'(m_left[k] == 1));
                if (m_left[k] == 1) begin
                    check($sformatf("prod[%0d] c%0d", k, cyc), getp(k), m_exp_p[k]);
                    check($sformatf("ovf[%0d] c%0d", k, cyc), longint'(ovf[k]), longint'(m_exp_o[k]));
                end else if (m_left[k] == 0) begin
                    check($sformatf("hold_prod[%0d] c%0d", k, cyc), getp(k), m_hold_p[k]);
                    check($sformatf("hold_ovf[%0d] c%0d", k, cyc), longint'(ovf[k]), longint'(m_hold_o[k]));
                end
            end
        end
    end

    task automatic set_ops(int k, longint a, longint b, bit s);
        if (k == 0) begin
            a12 = a[11:0];
            b12 = b[11:0];
        end else begin
            a8 = a[7:0];
            b8 = b[7:0];
        end
        sm[k] = s;
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the accept edge.
    task automatic start_op(int k, longint a, longint b, bit s, output int e0);
        set_ops(k, a, b, s);
        start[k] = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    // Returns at the negedge inside the done cycle; latency counts the accept cycle as 1.
    task automatic wait_done(int k, int e0, output int lat);
        int c = 0;
        lat = -1;
        if (done[k]) begin
            lat = cyc - e0 + 1;
        end else begin
            while (lat < 0 && c < 40) begin
                @(posedge clk);
                #1;
                c++;
                if (done[k]) lat = cyc - e0 + 1;
            end
            if (lat < 0) check("done_timeout", 0, 1);
            @(negedge clk);
        end
    endtask

    task automatic run_op(int k, longint a, longint b, bit s, longint exp_p, bit exp_o, int exp_lat);
        int e0;
        int lat;
        check($sformatf("model_prod %0h*%0h", a, b), model_p(a, b, s, wid(k)), exp_p);
        check($sformatf("model_ovf %0h*%0h", a, b), longint'(model_o(a, b, s, wid(k))), longint'(exp_o));
        start_op(k, a, b, s, e0);
        wait_done(k, e0, lat);
        check($sformatf("latency %0h*%0h", a, b), lat, exp_lat);
        check($sformatf("product %0h*%0h", a, b), getp(k), exp_p);
        check($sformatf("overflow %0h*%0h", a, b), longint'(ovf[k]), longint'(exp_o));
        @(negedge clk);
    endtask

    longint ba   [3] = '{3, 200, 255};
    longint bb   [3] = '{5, 2, 255};
    longint bexp [3] = '{'h000F, 'h0190, 'hFE01};
    bit     bovf [3] = '{1'b0, 1'b1, 1'b1};

    initial begin
        int e0;
        int lat;
        int prev;
        int c;
        bit found;

        for (int k = 0; k < 2; k++) begin
            rstn[k]  = 1'b0;
            start[k] = 1'b0;
            sm[k]    = 1'b0;
        end
        a12 = '0; b12 = '0; a8 = '0; b8 = '0;

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_prod[%0d]", k), getp(k), 0);
            check($sformatf("reset_ovf[%0d]", k), longint'(ovf[k]), 0);
            check($sformatf("reset_busy[%0d]", k), longint'(busy[k]), 0);
            check($sformatf("reset_done[%0d]", k), longint'(done[k]), 0);
        end
        @(negedge clk);
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;
        @(negedge clk);

        run_op(0, 'hFFF, 'hFFF, 1'b0, 'hFFE001, 1'b1, 14);
        run_op(0, 'hFFD, 'h005, 1'b1, 'hFFFFF1, 1'b0, 14);
        run_op(0, 'h800, 'h800, 1'b1, 'h400000, 1'b1, 14);

        // A second start during CALC must be ignored.
        start_op(0, 7, 9, 1'b0, e0);
        repeat (3) @(negedge clk);
        set_ops(0, 100, 200, 1'b0);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, e0, lat);
        check("ignored_start_latency", lat, 14);
        check("ignored_start_product", getp(0), 'h3F);
        check("ignored_start_ovf", longint'(ovf[0]), 0);
        @(negedge clk);

        // Reset in the middle of CALC aborts the operation.
        start_op(0, 'h123, 'h456, 1'b0, e0);
        repeat (5) @(negedge clk);
        rstn[0] = 1'b0;
        #1;
        check("abort_busy", longint'(busy[0]), 0);
        check("abort_product", getp(0), 0);
        check("abort_done", longint'(done[0]), 0);
        repeat (3) @(negedge clk);
        rstn[0] = 1'b1;
        @(negedge clk);
        run_op(0, 2, 3, 1'b0, 'h000006, 1'b0, 14);

        run_op(0, 0, 1234, 1'b0, 0, 1'b0, ZS ? 1 : 14);

        run_op(1, 'h7F, 'h80, 1'b1, 'hC080, 1'b1, 10);

        // start held high: back-to-back operations, operands re-sampled at each acceptance.
        set_ops(1, ba[0], bb[0], 1'b0);
        start[1] = 1'b1;
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            c = 0;
            found = 1'b0;
            while (!found && c < 40) begin
                @(posedge clk);
                #1;
                c++;
                if (done[1]) found = 1'b1;
            end
            if (!found) begin
                check($sformatf("b2b_timeout%0d", i), 0, 1);
            end else begin
                check($sformatf("b2b_product%0d", i), getp(1), bexp[i]);
                check($sformatf("b2b_ovf%0d", i), longint'(ovf[1]), longint'(bovf[i]));
                if (i > 0) check($sformatf("b2b_period%0d", i), cyc - prev, 11);
                prev = cyc;
            end
            @(negedge clk);
            if (i < 2) set_ops(1, ba[i+1], bb[i+1], 1'b0);
            else start[1] = 1'b0;
        end
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
